bounce_sprite_gen: RTL and testbench

Pixel-source stage directly upstream of the VGA timing block. It takes that block's horizontal and vertical counters and returns the 3-3-2 colour for every pixel. It draws a border, a background and a square ball that bounces inside the border, and the ball position advances once per frame during vertical blanking. A debounced-by-edge pause button freezes the ball, and the colour output is registered with one-pixel lookahead so it aligns exactly with the counters.

---
 rtl/bounce_sprite_gen.sv | 176 +++++++++++++++++
 tb/tb_bounce_sprite_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_sprite_gen.sv
// Pixel source for a 640x480 VGA timing block: border, background and a ball that bounces once per frame.
// Colour is computed for the next pixel and registered, so it lines up with the incoming counters.
module bounce_sprite_gen #(
    parameter int          BALL_SIZE    = 16,
    parameter int          SPEED        = 2,
    parameter int          BORDER       = 4,
    parameter int          X_INIT       = 312,
    parameter int          Y_INIT       = 232,
    parameter logic [7:0]  BALL_COLOR   = 8'hE0,
    parameter logic [7:0]  BG_COLOR     = 8'h03,
    parameter logic [7:0]  BORDER_COLOR = 8'hFF
) (
    input  logic       vgaclk,
    input  logic       rst,
    input  logic [9:0] hc_in,
    input  logic [9:0] vc_in,
    input  logic       pause_btn,
    output logic [2:0] out_red,
    output logic [2:0] out_green,
    output logic [1:0] out_blue,
    output logic       frame_tick,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       paused
);
    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_LAST  = 10'd524;
    localparam logic [9:0] H_ACT   = 10'd640;
    localparam logic [9:0] V_ACT   = 10'd480;
    localparam logic [9:0] BSZ     = 10'(BALL_SIZE);
    localparam logic [9:0] SPD     = 10'(SPEED);
    localparam logic [9:0] B_LO    = 10'(BORDER);
    localparam logic [9:0] B_RIGHT = 10'(640 - BORDER);
    localparam logic [9:0] B_BOT   = 10'(480 - BORDER);
    localparam logic [9:0] XMIN    = 10'(BORDER);
    localparam logic [9:0] XMAX    = 10'(640 - BORDER - BALL_SIZE);
    localparam logic [9:0] YMIN    = 10'(BORDER);
    localparam logic [9:0] YMAX    = 10'(480 - BORDER - BALL_SIZE);

    typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} state_t;

    state_t     state;
    logic [9:0] nx;
    logic [9:0] ny;
    logic [7:0] color;
    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic       pause_rise;
    logic       dx_pos;
    logic       dy_pos;
    logic       move_en;

    // Coordinate of the pixel the counters will show on the next clock.
    always_comb begin
        nx = hc_in + 10'd1;
        ny = vc_in;
        if (hc_in == H_LAST) begin
            nx = '0;
            ny = (vc_in == V_LAST) ? '0 : vc_in + 10'd1;
        end
    end

    always_comb begin
        color = BG_COLOR;
        if (nx >= H_ACT || ny >= V_ACT) begin
            color = '0;
        end else if (nx < B_LO || nx >= B_RIGHT || ny < B_LO || ny >= B_BOT) begin
            color = BORDER_COLOR;
        end else if (nx >= ball_x && nx < ball_x + BSZ &&
                     ny >= ball_y && ny < ball_y + BSZ) begin
            color = BALL_COLOR;
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
        end else begin
            out_red   <= color[7:5];
            out_green <= color[4:2];
            out_blue  <= color[1:0];
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (hc_in == 10'd0) && (vc_in == V_ACT);
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= pause_btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pause_rise = sync2 & ~sync3;

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            paused <= 1'b0;
        end else if (pause_rise) begin
            case (state)
                ST_RUN: begin
                    state  <= ST_PAUSE;
                    paused <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    paused <= 1'b0;
                end
            endcase
        end
    end

    // Uses the state before any coincident toggle, so a pause edge on a tick still moves.
    assign move_en = frame_tick && (state == ST_RUN);

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            ball_x <= 10'(X_INIT);
            dx_pos <= 1'b1;
        end else if (move_en) begin
            if (dx_pos) begin
                if (ball_x + SPD >= XMAX) begin
                    ball_x <= XMAX;
                    dx_pos <= 1'b0;
                end else begin
                    ball_x <= ball_x + SPD;
                end
            end else begin
                if (ball_x <= XMIN + SPD) begin
                    ball_x <= XMIN;
                    dx_pos <= 1'b1;
                end else begin
                    ball_x <= ball_x - SPD;
                end
            end
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            ball_y <= 10'(Y_INIT);
            dy_pos <= 1'b1;
        end else if (move_en) begin
            if (dy_pos) begin
                if (ball_y + SPD >= YMAX) begin
                    ball_y <= YMAX;
                    dy_pos <= 1'b0;
                end else begin
                    ball_y <= ball_y + SPD;
                end
            end else begin
                if (ball_y <= YMIN + SPD) begin
                    ball_y <= YMIN;
                    dy_pos <= 1'b1;
                end else begin
                    ball_y <= ball_y - SPD;
                end
            end
        end
    end
endmodule

// File: tb/tb_bounce_sprite_gen.sv
// Bench for bounce_sprite_gen: colour table, random pixels against a scene model, motion, pause and reset.
module tb_bounce_sprite_gen;
    localparam int BALL_SIZE = 16;
    localparam int SPEED     = 2;
    localparam int BORDER    = 4;
    localparam int X_INIT    = 312;
    localparam int Y_INIT    = 232;
    localparam int XMIN      = BORDER;
    localparam int XMAX      = 640 - BORDER - BALL_SIZE;
    localparam int YMIN      = BORDER;
    localparam int YMAX      = 480 - BORDER - BALL_SIZE;

    logic       vgaclk = 1'b0;
    logic       rst;
    logic [9:0] hc_in;
    logic [9:0] vc_in;
    logic       pause_btn;
    logic [2:0] out_red;
    logic [2:0] out_green;
    logic [1:0] out_blue;
    logic       frame_tick;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       paused;

    int total = 0;
    int bad   = 0;

    // Scene model: ball position, direction per axis, and pause flag.
    int mx, my, mdx, mdy;
    bit mpaused;

    typedef struct {
        int         px;
        int         py;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[15];

    bounce_sprite_gen #(
        .BALL_SIZE(BALL_SIZE), .SPEED(SPEED), .BORDER(BORDER),
        .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .BALL_COLOR(8'hE0), .BG_COLOR(8'h03), .BORDER_COLOR(8'hFF)
    ) dut (
        .vgaclk(vgaclk), .rst(rst), .hc_in(hc_in), .vc_in(vc_in),
        .pause_btn(pause_btn), .out_red(out_red), .out_green(out_green),
        .out_blue(out_blue), .frame_tick(frame_tick), .ball_x(ball_x),
        .ball_y(ball_y), .paused(paused)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic step();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic set_cnt(input int h, input int v);
        hc_in = 10'(h);
        vc_in = 10'(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rgb();
        return int'({out_red, out_green, out_blue});
    endfunction

    function automatic logic [7:0] ref_color(input int x, input int y);
        if (x >= 640 || y >= 480) return 8'h00;
        if (x < BORDER || x >= 640 - BORDER || y < BORDER || y >= 480 - BORDER) return 8'hFF;
        if (x >= mx && x < mx + BALL_SIZE && y >= my && y < my + BALL_SIZE) return 8'hE0;
        return 8'h03;
    endfunction

    function automatic void model_reset();
        mx = X_INIT;
        my = Y_INIT;
        mdx = 1;
        mdy = 1;
        mpaused = 1'b0;
    endfunction

    // Step by SPEED, clamp at the wall and reverse.
    function automatic void model_move();
        if (mpaused) return;
        mx += mdx * SPEED;
        if (mx >= XMAX) begin mx = XMAX; mdx = -1; end
        else if (mx <= XMIN) begin mx = XMIN; mdx = 1; end
        my += mdy * SPEED;
        if (my >= YMAX) begin my = YMAX; mdy = -1; end
        else if (my <= YMIN) begin my = YMIN; mdy = 1; end
    endfunction

    // Drive the counter value that precedes pixel (px,py), then check the colour shown with it.
    task automatic chk_pixel(input string nm, input int px, input int py, input int exp);
        if (px > 0) set_cnt(px - 1, py);
        else set_cnt(799, (py > 0) ? py - 1 : 524);
        step();
        chk(nm, rgb(), exp);
    endtask

    task automatic do_tick();
        set_cnt(0, 480);
        chk("tick_pre", int'(frame_tick), 0);
        step();
        set_cnt(1, 480);
        chk("tick_high", int'(frame_tick), 1);
        step();
        set_cnt(10, 490);
        chk("tick_width", int'(frame_tick), 0);
        model_move();
        chk("ball_x", int'(ball_x), mx);
        chk("ball_y", int'(ball_y), my);
        chk("paused", int'(paused), int'(mpaused));
    endtask

    task automatic pulse_pause();
        set_cnt(5, 100);
        pause_btn = 1'b1;
        repeat (3) step();
        mpaused = ~mpaused;
        chk("pause_latency", int'(paused), int'(mpaused));
        pause_btn = 1'b0;
        repeat (4) step();
        chk("pause_level", int'(paused), int'(mpaused));
    endtask

    task automatic random_pixels(input int n);
        int px, py;
        for (int i = 0; i < n; i++) begin
            px = int'($urandom_range(799, 0));
            py = int'($urandom_range(524, 0));
            if (px == 1 && py == 480) px = 2;
            chk_pixel("rand_pixel", px, py, int'(ref_color(px, py)));
        end
    endtask

    initial begin
        int x0, y0, guard;

        vecs[0]  = '{0,   0,   8'hFF};
        vecs[1]  = '{320, 100, 8'h03};
        vecs[2]  = '{312, 232, 8'hE0};
        vecs[3]  = '{700, 10,  8'h00};
        vecs[4]  = '{3,   100, 8'hFF};
        vecs[5]  = '{4,   100, 8'h03};
        vecs[6]  = '{635, 200, 8'h03};
        vecs[7]  = '{636, 200, 8'hFF};
        vecs[8]  = '{640, 200, 8'h00};
        vecs[9]  = '{327, 247, 8'hE0};
        vecs[10] = '{328, 247, 8'h03};
        vecs[11] = '{312, 231, 8'h03};
        vecs[12] = '{100, 475, 8'h03};
        vecs[13] = '{100, 476, 8'hFF};
        vecs[14] = '{100, 480, 8'h00};

        rst = 1'b1;
        pause_btn = 1'b0;
        set_cnt(0, 0);
        model_reset();
        repeat (3) step();
        chk("rst_color", rgb(), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_x", int'(ball_x), X_INIT);
        chk("rst_y", int'(ball_y), Y_INIT);
        chk("rst_paused", int'(paused), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            chk_pixel($sformatf("table_%0d_%0d", vecs[i].px, vecs[i].py),
                      vecs[i].px, vecs[i].py, int'(vecs[i].exp));
        end

        // Frame wrap: the value latched while hc=799 is the (0,0) border colour.
        set_cnt(798, 524);
        step();
        set_cnt(799, 524);
        chk("wrap_799", rgb(), 0);
        step();
        set_cnt(0, 0);
        chk("wrap_00", rgb(), 8'hFF);
        step();

        random_pixels(200);

        for (int t = 1; t <= 155; t++) begin
            do_tick();
            if (t == 114) chk("y_bounce_114", int'(ball_y), 460);
            if (t == 115) chk("y_after_115", int'(ball_y), 458);
            if (t == 154) chk("x_bounce_154", int'(ball_x), 620);
            if (t == 155) chk("x_after_155", int'(ball_x), 618);
        end

        guard = 0;
        while (!(mx == 6 && mdx == -1) && guard < 1000) begin
            do_tick();
            guard++;
        end
        chk("reach_x6_in_budget", int'(guard < 1000), 1);
        chk("x_at_6", int'(ball_x), 6);
        do_tick();
        chk("x_left_wall", int'(ball_x), 4);
        do_tick();
        chk("x_rebound", int'(ball_x), 6);

        random_pixels(60);

        pulse_pause();
        x0 = mx;
        y0 = my;
        repeat (5) do_tick();
        chk("pause_hold_x", int'(ball_x), x0);
        chk("pause_hold_y", int'(ball_y), y0);
        random_pixels(40);

        pulse_pause();
        chk("resumed", int'(paused), 0);
        do_tick();
        chk("resume_dx", (int'(ball_x) > x0) ? int'(ball_x) - x0 : x0 - int'(ball_x), SPEED);

        // Synchronised pause edge lands in the same cycle as frame_tick.
        set_cnt(5, 100);
        pause_btn = 1'b1;
        x0 = int'(ball_x);
        step();
        set_cnt(0, 480);
        step();
        set_cnt(1, 480);
        chk("coinc_tick", int'(frame_tick), 1);
        step();
        set_cnt(10, 490);
        model_move();
        mpaused = 1'b1;
        chk("coinc_x", int'(ball_x), mx);
        chk("coinc_y", int'(ball_y), my);
        chk("coinc_moved", int'(int'(ball_x) != x0), 1);
        chk("coinc_paused", int'(paused), 1);
        step();
        pause_btn = 1'b0;
        repeat (4) step();

        random_pixels(40);

        set_cnt(399, 200);
        step();
        set_cnt(400, 200);
        chk("pre_rst_color", rgb(), int'(ref_color(400, 200)));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_color", rgb(), 0);
        chk("async_rst_x", int'(ball_x), X_INIT);
        chk("async_rst_y", int'(ball_y), Y_INIT);
        chk("async_rst_paused", int'(paused), 0);
        chk("async_rst_tick", int'(frame_tick), 0);
        step();
        rst = 1'b0;
        model_reset();
        step();
        do_tick();
        chk("post_rst_x", int'(ball_x), X_INIT + SPEED);
        chk("post_rst_y", int'(ball_y), Y_INIT + SPEED);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
